instr_fetch: RTL and testbench
==============================

Name: instr_fetch

Overview:
Instruction-fetch stage of the 5-stage MIPS pipeline, directly upstream of the IF/ID pipeline register, which it feeds with pcAdd4IF and instructionIF.
- Owns the PC and next-PC selection (sequential, branch, jump).
- Runs a req/ready handshake to instruction memory with variable latency.
- Buffers one returned instruction while the pipeline is held.
- Inserts NOP bubbles (32'h0) on memory wait and on redirects.

Parameters:
RESET_PC, 32'h0000_0000, PC loaded on reset.

Ports:
clk  in  1  pipeline clock, all state on posedge
reset  in  1  asynchronous, active-high; clears all state immediately
hold  in  1  stall from hazard unit (same signal that drives IF/ID hold)
branchTaken  in  1  branch resolved taken in ID
branchTarget  in  32  branch target address
jump  in  1  jump decoded in ID
jumpTarget  in  32  jump target address
imemReady  in  1  memory returns imemData for the outstanding request this cycle
imemData  in  32  instruction word
imemReq  out  1  request outstanding (combinational from state)
imemAddr  out  32  request address (registered reqAddr)
pcAdd4IF  out  32  address of fetched instruction + 4
instructionIF  out  32  fetched instruction, 32'h0 on bubble
validIF  out  1  instructionIF is a real instruction

Behaviour:
- Registers:
  - pc: next address to fetch.
  - reqAddr: address of the outstanding request.
  - state: IDLE, FETCH, HELD, DRAIN.
  - skid pair: skidInstr, skidPcAdd4.
  - output registers: instructionIF, pcAdd4IF, validIF.
- Reset (async):
  - pc = reqAddr = RESET_PC; state = IDLE.
  - All outputs and skid registers = 0; imemReq = 0.
- imemReq = 1 in FETCH and DRAIN only.
- imemAddr = reqAddr, held stable while imemReq = 1 and imemReady = 0.
- Redirect target: jump ? jumpTarget : branchTarget. Jump wins when jump and branchTaken are both high. Target bits [1:0] are forced to 0.
- Arithmetic: all +4 operations are 32-bit and wrap modulo 2^32 (32'hFFFF_FFFC + 4 = 0).
- Priority per posedge: redirect > hold > normal.
- Redirect (jump | branchTaken), hold ignored:
  - Outputs <= bubble (instr 0, pcAdd4 0, valid 0); pc <= target.
  - IDLE, HELD (skid discarded), or FETCH with imemReady: reqAddr <= target, state -> FETCH. Any returned data is discarded.
  - FETCH with !imemReady: state -> DRAIN; reqAddr unchanged.
  - DRAIN: stays DRAIN; only pc is updated.
- Hold, no redirect:
  - Outputs unchanged.
  - FETCH & imemReady: skidInstr <= imemData, skidPcAdd4 <= reqAddr+4, pc <= reqAddr+4, state -> HELD.
  - FETCH & !imemReady: no change.
  - HELD: no change.
  - DRAIN & imemReady: reqAddr <= pc, state -> FETCH.
  - IDLE: state -> FETCH.
- Normal (no hold, no redirect):
  - IDLE: outputs bubble, reqAddr <= pc, state -> FETCH.
  - FETCH & imemReady: instructionIF <= imemData, pcAdd4IF <= reqAddr+4, validIF <= 1, pc = reqAddr <= reqAddr+4. Sustains 1 instr/cycle with a zero-wait memory.
  - FETCH & !imemReady: outputs bubble.
  - HELD: outputs <= skid pair, validIF <= 1, reqAddr <= pc, state -> FETCH. imemReq is 0 during the HELD cycle.
  - DRAIN: outputs bubble; on imemReady, reqAddr <= pc, state -> FETCH.
- Latency:
  - With zero-wait memory, the first valid instruction appears at the second posedge after reset release (IDLE, then FETCH).
  - Redirect costs one bubble plus any drain cycles.
- imemReady while imemReq = 0 is ignored.
- Reset mid-request abandons the request; memory must tolerate req dropping.

Decomposition:
- Shared defines header (guarded include): state encodings, NOP = 32'h0, default RESET_PC.
- One natural sub-module, fetch_skid: 1-entry buffer with load/drain/clear for the skid pair.
- PC/next-PC logic and the FSM stay in instr_fetch.

Test Plan:
- Reset release, imemReady tied 1, imemData = addr-derived → imemAddr 0,4,8,…; pcAdd4IF 4,8,12 on consecutive cycles; validIF = 1 from 2nd posedge.
- imemReady low 2 cycles at addr 8 → imemAddr holds 8; two bubbles (instr 0, valid 0); then pcAdd4IF = 12.
- hold high 1 cycle while data for addr 4 returns → outputs frozen; next cycle pcAdd4IF = 8 from skid; then fetch resumes at 8 with no lost or duplicated instruction.
- branchTaken, target 32'h40, in FETCH with ready → one bubble; imemAddr = 32'h40 next cycle; then pcAdd4IF = 32'h44.
- jump to 32'h100 and branchTaken to 32'h40 together while waiting (ready low 3 cycles) → DRAIN; old data discarded; next request 32'h100; then pcAdd4IF = 32'h104.
- Async reset asserted mid-wait between clock edges → outputs 0 and imemReq 0 immediately; refetch from RESET_PC after release; PC 32'hFFFF_FFFC wraps to 0.

Source files
------------

// File: rtl/instr_fetch_pkg.sv
// rtl/instr_fetch_pkg.sv - shared constants for the instruction-fetch stage
package instr_fetch_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_FETCH = 2'd1;
    localparam logic [1:0] ST_HELD  = 2'd2;
    localparam logic [1:0] ST_DRAIN = 2'd3;

    localparam logic [31:0] NOP              = 32'h0000_0000;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_skid.sv
// rtl/fetch_skid.sv - one-entry buffer for an instruction returned while the pipe is held
module fetch_skid (
    input  logic        clk,
    input  logic        reset,
    input  logic        load_i,
    input  logic        drain_i,
    input  logic        clear_i,
    input  logic [31:0] instr_i,
    input  logic [31:0] pc_add4_i,
    output logic [31:0] instr_o,
    output logic [31:0] pc_add4_o
);

    logic [31:0] instr_q;
    logic [31:0] pc_add4_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            instr_q   <= 32'h0;
            pc_add4_q <= 32'h0;
        end else if (load_i) begin
            instr_q   <= instr_i;
            pc_add4_q <= pc_add4_i;
        end else if (drain_i || clear_i) begin
            instr_q   <= 32'h0;
            pc_add4_q <= 32'h0;
        end
    end

    assign instr_o   = instr_q;
    assign pc_add4_o = pc_add4_q;

endmodule

// File: rtl/instr_fetch.sv
// rtl/instr_fetch.sv - IF stage: PC/next-PC selection, imem handshake, skid and bubble insertion
module instr_fetch
    import instr_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        hold,
    input  logic        branchTaken,
    input  logic [31:0] branchTarget,
    input  logic        jump,
    input  logic [31:0] jumpTarget,
    input  logic        imemReady,
    input  logic [31:0] imemData,
    output logic        imemReq,
    output logic [31:0] imemAddr,
    output logic [31:0] pcAdd4IF,
    output logic [31:0] instructionIF,
    output logic        validIF
);

    logic [1:0]  state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] req_addr_q, req_addr_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] pc_add4_q, pc_add4_d;
    logic        valid_q, valid_d;
    logic        skid_load, skid_drain, skid_clear;
    logic [31:0] skid_instr, skid_pc_add4;
    logic        redirect;
    logic [31:0] target;
    logic [31:0] seq_addr;

    assign redirect = jump || branchTaken;
    assign target   = word_align(jump ? jumpTarget : branchTarget);
    assign seq_addr = req_addr_q + 32'd4;

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        req_addr_d = req_addr_q;
        instr_d    = instr_q;
        pc_add4_d  = pc_add4_q;
        valid_d    = valid_q;
        skid_load  = 1'b0;
        skid_drain = 1'b0;
        skid_clear = 1'b0;
        if (redirect) begin
            instr_d   = NOP;
            pc_add4_d = NOP;
            valid_d   = 1'b0;
            pc_d      = target;
            case (state_q)
                ST_FETCH: begin
                    // An unanswered request must be drained before a new address is issued.
                    if (imemReady) req_addr_d = target;
                    else           state_d    = ST_DRAIN;
                end
                ST_DRAIN: ;
                default: begin
                    req_addr_d = target;
                    state_d    = ST_FETCH;
                    skid_clear = 1'b1;
                end
            endcase
        end else if (hold) begin
            case (state_q)
                ST_IDLE: state_d = ST_FETCH;
                ST_FETCH: begin
                    if (imemReady) begin
                        skid_load = 1'b1;
                        pc_d      = seq_addr;
                        state_d   = ST_HELD;
                    end
                end
                ST_DRAIN: begin
                    if (imemReady) begin
                        req_addr_d = pc_q;
                        state_d    = ST_FETCH;
                    end
                end
                default: ;
            endcase
        end else begin
            case (state_q)
                ST_IDLE: begin
                    instr_d    = NOP;
                    pc_add4_d  = NOP;
                    valid_d    = 1'b0;
                    req_addr_d = pc_q;
                    state_d    = ST_FETCH;
                end
                ST_FETCH: begin
                    if (imemReady) begin
                        instr_d    = imemData;
                        pc_add4_d  = seq_addr;
                        valid_d    = 1'b1;
                        pc_d       = seq_addr;
                        req_addr_d = seq_addr;
                    end else begin
                        instr_d   = NOP;
                        pc_add4_d = NOP;
                        valid_d   = 1'b0;
                    end
                end
                ST_HELD: begin
                    instr_d    = skid_instr;
                    pc_add4_d  = skid_pc_add4;
                    valid_d    = 1'b1;
                    skid_drain = 1'b1;
                    req_addr_d = pc_q;
                    state_d    = ST_FETCH;
                end
                default: begin
                    instr_d   = NOP;
                    pc_add4_d = NOP;
                    valid_d   = 1'b0;
                    if (imemReady) begin
                        req_addr_d = pc_q;
                        state_d    = ST_FETCH;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            pc_q       <= RESET_PC;
            req_addr_q <= RESET_PC;
            instr_q    <= NOP;
            pc_add4_q  <= 32'h0;
            valid_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            req_addr_q <= req_addr_d;
            instr_q    <= instr_d;
            pc_add4_q  <= pc_add4_d;
            valid_q    <= valid_d;
        end
    end

    fetch_skid u_skid (
        .clk       (clk),
        .reset     (reset),
        .load_i    (skid_load),
        .drain_i   (skid_drain),
        .clear_i   (skid_clear),
        .instr_i   (imemData),
        .pc_add4_i (seq_addr),
        .instr_o   (skid_instr),
        .pc_add4_o (skid_pc_add4)
    );

    assign imemReq       = (state_q == ST_FETCH) || (state_q == ST_DRAIN);
    assign imemAddr      = req_addr_q;
    assign instructionIF = instr_q;
    assign pcAdd4IF      = pc_add4_q;
    assign validIF       = valid_q;

endmodule

// File: tb/tb_instr_fetch.sv
// tb/tb_instr_fetch.sv - scoreboard bench for instr_fetch against a transaction-level model
module tb_instr_fetch;

    logic        clk;
    logic        reset;
    logic        hold;
    logic        branchTaken;
    logic [31:0] branchTarget;
    logic        jump;
    logic [31:0] jumpTarget;
    logic        imemReady;
    logic [31:0] imemData;
    logic        imemReq;
    logic [31:0] imemAddr;
    logic [31:0] pcAdd4IF;
    logic [31:0] instructionIF;
    logic        validIF;

    instr_fetch #(.RESET_PC(32'h0000_0000)) dut (
        .clk           (clk),
        .reset         (reset),
        .hold          (hold),
        .branchTaken   (branchTaken),
        .branchTarget  (branchTarget),
        .jump          (jump),
        .jumpTarget    (jumpTarget),
        .imemReady     (imemReady),
        .imemData      (imemData),
        .imemReq       (imemReq),
        .imemAddr      (imemAddr),
        .pcAdd4IF      (pcAdd4IF),
        .instructionIF (instructionIF),
        .validIF       (validIF)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] memfn(input logic [31:0] a);
        return {a[15:0] ^ 16'h1234, a[31:16] ^ 16'hBEEF};
    endfunction

    assign imemData = memfn(imemAddr);

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc4;
    } exp_t;

    exp_t exp_q[$];
    exp_t last_exp;
    int   ntests = 0;
    int   nfail  = 0;

    // reference model: program-order view of the fetch unit
    logic [31:0] m_pc, m_req, m_buf_instr, m_buf_pc4;
    logic        m_busy, m_discard, m_buf, m_started;
    logic        upd_pending, vexp_next, upd_q, vexp_q;

    always @(posedge clk) begin
        upd_q  <= upd_pending;
        vexp_q <= vexp_next;
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        ntests++;
        if (got !== exp) begin
            nfail++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_pc = 32'h0; m_req = 32'h0; m_buf_instr = 32'h0; m_buf_pc4 = 32'h0;
        m_busy = 1'b0; m_discard = 1'b0; m_buf = 1'b0; m_started = 1'b0;
        upd_pending = 1'b1; vexp_next = 1'b0;
        last_exp = '{32'h0, 32'h0};
        exp_q.delete();
    endtask

    task automatic model_step(input logic h, input logic br, input logic [31:0] bt,
                              input logic jp, input logic [31:0] jt, input logic rdy);
        logic [31:0] tgt;
        logic [31:0] d;
        logic        r;
        r   = rdy && m_busy;
        tgt = jp ? jt : bt;
        tgt[1:0] = 2'b00;
        upd_pending = br || jp || !h;
        if (br || jp) begin
            vexp_next = 1'b0;
            m_pc      = tgt;
            m_buf     = 1'b0;
            m_started = 1'b1;
            if (m_busy && m_discard) begin
                m_discard = 1'b1;
            end else if (m_busy && !r) begin
                m_discard = 1'b1;
            end else begin
                m_req  = tgt;
                m_busy = 1'b1;
            end
        end else if (!m_started) begin
            m_started = 1'b1;
            m_busy    = 1'b1;
            if (!h) vexp_next = 1'b0;
        end else if (m_buf) begin
            if (!h) begin
                exp_q.push_back('{m_buf_instr, m_buf_pc4});
                vexp_next = 1'b1;
                m_buf     = 1'b0;
                m_busy    = 1'b1;
                m_req     = m_pc;
            end
        end else if (m_discard) begin
            if (!h) vexp_next = 1'b0;
            if (r) begin
                m_discard = 1'b0;
                m_req     = m_pc;
            end
        end else if (r) begin
            d = memfn(m_req);
            if (h) begin
                m_buf       = 1'b1;
                m_buf_instr = d;
                m_buf_pc4   = m_req + 32'd4;
                m_pc        = m_req + 32'd4;
                m_busy      = 1'b0;
            end else begin
                exp_q.push_back('{d, m_req + 32'd4});
                vexp_next = 1'b1;
                m_req     = m_req + 32'd4;
                m_pc      = m_req;
            end
        end else if (!h) begin
            vexp_next = 1'b0;
        end
    endtask

    // one clock: check request side, drive inputs, advance the model; returns at the next negedge
    task automatic cycle(input logic h, input logic br, input logic [31:0] bt,
                         input logic jp, input logic [31:0] jt, input logic rdy);
        chk("imemReq", imemReq, m_busy);
        if (m_busy) chk("imemAddr", imemAddr, m_req);
        hold = h; branchTaken = br; branchTarget = bt;
        jump = jp; jumpTarget = jt; imemReady = rdy;
        model_step(h, br, bt, jp, jt, rdy);
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic async_reset_mid_cycle();
        imemReady = 1'b0; hold = 1'b0; branchTaken = 1'b0; jump = 1'b0;
        #2 reset = 1'b1;
        #1;
        chk("rst_imemReq", imemReq, 1'b0);
        chk("rst_validIF", validIF, 1'b0);
        chk("rst_instr", instructionIF, 32'h0);
        chk("rst_pcAdd4", pcAdd4IF, 32'h0);
        chk("rst_imemAddr", imemAddr, 32'h0);
        model_reset();
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            chk("validIF", validIF, vexp_q);
            if (validIF && upd_q) begin
                if (exp_q.size() == 0) begin
                    chk("scoreboard_underflow", 32'd0, 32'd1);
                end else begin
                    last_exp = exp_q.pop_front();
                    chk("instructionIF", instructionIF, last_exp.instr);
                    chk("pcAdd4IF", pcAdd4IF, last_exp.pc4);
                end
            end else if (validIF) begin
                chk("held_instr", instructionIF, last_exp.instr);
                chk("held_pcAdd4", pcAdd4IF, last_exp.pc4);
            end else begin
                chk("bubble_instr", instructionIF, 32'h0);
                chk("bubble_pcAdd4", pcAdd4IF, 32'h0);
            end
        end
    end

    initial begin
        reset = 1'b1; hold = 1'b0; branchTaken = 1'b0; branchTarget = 32'h0;
        jump = 1'b0; jumpTarget = 32'h0; imemReady = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        reset = 1'b0;
        chk("reset_imemReq", imemReq, 1'b0);
        chk("reset_imemAddr", imemAddr, 32'h0);
        chk("reset_validIF", validIF, 1'b0);

        cycle(0, 0, 0, 0, 0, 1);
        chk("idle_to_fetch_req", imemReq, 1'b1);
        cycle(0, 0, 0, 0, 0, 1);
        chk("first_valid", validIF, 1'b1);
        chk("first_pcAdd4", pcAdd4IF, 32'h4);
        cycle(1, 0, 0, 0, 0, 1);
        chk("hold_frozen_pcAdd4", pcAdd4IF, 32'h4);
        chk("held_no_req", imemReq, 1'b0);
        cycle(0, 0, 0, 0, 0, 0);
        chk("skid_pcAdd4", pcAdd4IF, 32'h8);
        chk("resume_addr", imemAddr, 32'h8);
        repeat (2) begin
            cycle(0, 0, 0, 0, 0, 0);
            chk("wait_addr_stable", imemAddr, 32'h8);
            chk("wait_bubble", validIF, 1'b0);
        end
        cycle(0, 0, 0, 0, 0, 1);
        chk("after_wait_pcAdd4", pcAdd4IF, 32'hC);
        cycle(0, 0, 0, 0, 0, 1);
        cycle(0, 1, 32'h40, 0, 0, 1);
        chk("branch_bubble", validIF, 1'b0);
        chk("branch_addr", imemAddr, 32'h40);
        cycle(0, 0, 0, 0, 0, 1);
        chk("branch_pcAdd4", pcAdd4IF, 32'h44);
        cycle(0, 1, 32'h40, 1, 32'h100, 0);
        cycle(0, 0, 0, 0, 0, 0);
        cycle(0, 0, 0, 0, 0, 0);
        cycle(0, 0, 0, 0, 0, 1);
        chk("drain_bubble", validIF, 1'b0);
        chk("drain_new_addr", imemAddr, 32'h100);
        cycle(0, 0, 0, 0, 0, 1);
        chk("jump_pcAdd4", pcAdd4IF, 32'h104);
        cycle(0, 0, 0, 1, 32'hFFFF_FFFE, 1);
        chk("aligned_target", imemAddr, 32'hFFFF_FFFC);
        cycle(0, 0, 0, 0, 0, 1);
        chk("wrap_pcAdd4", pcAdd4IF, 32'h0);
        chk("wrap_addr", imemAddr, 32'h0);
        async_reset_mid_cycle();
        cycle(0, 0, 0, 0, 0, 1);
        cycle(0, 0, 0, 0, 0, 1);
        chk("refetch_pcAdd4", pcAdd4IF, 32'h4);

        for (int i = 0; i < 3000; i++) begin
            logic [3:0]  r;
            logic [31:0] bt, jt;
            r  = 4'($urandom_range(0, 15));
            bt = ($urandom_range(0, 7) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15))) : $urandom;
            jt = $urandom;
            cycle($urandom_range(0, 3) == 0, (r == 0) || (r == 2), bt,
                  (r == 1) || (r == 2), jt, $urandom_range(0, 9) < 7);
            if (i == 1500) async_reset_mid_cycle();
        end
        repeat (3) cycle(1, 0, 0, 0, 0, 0);
        chk("scoreboard_empty", exp_q.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule
